// File: rtl/pc_fetch_driver.sv
// Fetch-side writer for the program counter: picks the next PC and its write enable,
// buffers redirects the PC cannot take yet, tracks icache miss and halt state, and counts activity.
module pc_fetch_driver #(
   parameter int WORD_W = 32,
   parameter int PC_INC = 4,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [WORD_W-1:0] pc_out,
   input  logic              ihit,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [WORD_W-1:0] redirect_target,
   input  logic              halt,
   output logic [WORD_W-1:0] pc_in,
   output logic              pc_WEN,
   output logic              iREN,
   output logic              redirect_pend,
   output logic              halted,
   output logic              align_err,
   output logic [CNT_W-1:0]  fetch_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   typedef enum logic [1:0] {RUN, MISS, HALTED} state_t;

   localparam logic [WORD_W-1:0] INC = WORD_W'(PC_INC);

   state_t            state_reg, state_next;
   logic              pend_valid_reg, pend_valid_next;
   logic [WORD_W-1:0] pend_target_reg, pend_target_next;
   logic              align_err_reg, align_err_next;
   logic [CNT_W-1:0]  fetch_cnt_reg, miss_cnt_reg;

   logic              active;
   logic              advance;
   logic              halt_take;
   logic [WORD_W-1:0] redirect_aligned;

   assign redirect_aligned = {redirect_target[WORD_W-1:2], 2'b00};
   assign active           = (state_reg != HALTED);
   // Gating with nRST keeps the PC and icache quiet while reset is held.
   assign advance          = nRST & active & ihit & ~stall & ~halt;
   assign halt_take        = active & ihit & ~stall & halt;

   assign pc_WEN        = advance;
   assign iREN          = nRST & active;
   assign redirect_pend = pend_valid_reg;
   assign halted        = (state_reg == HALTED);
   assign align_err     = align_err_reg;
   assign fetch_cnt     = fetch_cnt_reg;
   assign miss_cnt      = miss_cnt_reg;

   always_comb begin
      pc_in = pc_out + INC;
      if (redirect_valid)
         pc_in = redirect_aligned;
      else if (pend_valid_reg)
         pc_in = pend_target_reg;
   end

   always_comb begin
      state_next       = state_reg;
      pend_valid_next  = pend_valid_reg;
      pend_target_next = pend_target_reg;
      align_err_next   = align_err_reg;
      if (active) begin
         if (redirect_valid && (redirect_target[1:0] != 2'b00))
            align_err_next = 1'b1;
         if (halt_take) begin
            state_next      = HALTED;
            pend_valid_next = 1'b0;
         end else begin
            state_next = ihit ? RUN : MISS;
            // A redirect that cannot be taken now is held; the newest one wins.
            if (redirect_valid && !advance) begin
               pend_valid_next  = 1'b1;
               pend_target_next = redirect_aligned;
            end else if (advance) begin
               pend_valid_next = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg       <= RUN;
         pend_valid_reg  <= 1'b0;
         pend_target_reg <= '0;
         align_err_reg   <= 1'b0;
         fetch_cnt_reg   <= '0;
         miss_cnt_reg    <= '0;
      end else begin
         state_reg       <= state_next;
         pend_valid_reg  <= pend_valid_next;
         pend_target_reg <= pend_target_next;
         align_err_reg   <= align_err_next;
         if (advance && (fetch_cnt_reg != '1))
            fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
         if ((state_reg == MISS) && (miss_cnt_reg != '1))
            miss_cnt_reg <= miss_cnt_reg + 1'b1;
      end
   end

endmodule
